dm_hs: RTL and testbench
========================

// Module: dm_hs
// PURPOSE
//  Parametrised data memory for the multicycle CPU with a req/ack handshake and programmable wait states.
//  Accepts byte/half/word (and dword when DW=64) loads and stores at byte addresses.
//  Steers lanes internally and sign/zero-extends load data, so the datapath needs no external be/extend logic.
//  Flags misaligned or out-of-range accesses instead of silently corrupting memory. Sits between ALU address
//  output and MDR.
// PARAMETERS
//  DW     32    data width, 32 or 64 only
//  DEPTH  3072  number of DW-bit words
//  AW     14    byte-address width; must satisfy DEPTH*DW/8 <= 2**AW
//  LAT    1     wait states before the access, 0..15
// PORTS
//  clk    in   1      clock; all state updates on posedge
//  rst_n  in   1      asynchronous active-low reset
//  req    in   1      access request; hold high until ack
//  we     in   1      1=store, 0=load; sampled with req
//  addr   in   AW     byte address
//  size   in   2      00 byte, 01 half, 10 word, 11 dword (legal only if DW=64)
//  sext   in   1      loads: 1=sign-extend, 0=zero-extend
//  wdata  in   DW     store data, right-justified (low bytes)
//  ack    out  1      one-cycle completion pulse
//  rdata  out  DW     load result, extended, valid while ack=1, else 0
//  err    out  1      valid while ack=1: misaligned/out-of-range/illegal size
// BEHAVIOUR
//  Reset (async assert): state=IDLE, ack=0, err=0, rdata=0, wait counter=0. Memory array is never reset.
//  FSM: IDLE -> (req) -> WAIT (LAT>0) or ACCESS (LAT=0); WAIT counts LAT cycles -> ACCESS; ACCESS -> RESP; RESP -> IDLE.
//  req/we/addr/size/sext/wdata are latched on the IDLE cycle where req=1; later input changes have no effect.
//  ACCESS: the array read or write occurs. RESP: ack=1 for exactly one cycle, with rdata/err.
//  Latency: ack is high LAT+2 cycles after the req-accept edge. Back-to-back throughput: one access per LAT+3 cycles.
//  req in WAIT/ACCESS/RESP is ignored, not queued. The requester drops req the cycle after ack.
//   If req is still high in IDLE, a new access starts.
//  Alignment: the access is legal if addr % (1<<size) == 0. Word index = addr >> log2(DW/8); legal if < DEPTH.
//  Illegal access: no array write, rdata=0, err=1 with ack. Timing is identical to a legal access.
//  Store: byte enables derive from size and addr lane bits. wdata low bytes are shifted into the addressed lane.
//   Untouched bytes keep their value.
//  Load: the addressed lane is extracted, then extended to DW from bit (8<<size)-1 per sext. A full-width load ignores sext.
//  Async reset during WAIT/ACCESS: access is abandoned and no ack is issued.
//   A store whose ACCESS edge coincides with reset assertion is not guaranteed to land.
//  LAT is a parameter, not runtime; the counter width is $clog2(LAT+1), minimum 1.
// CONFIGURATION
//  DM_PARITY_EN defined: each byte stores one extra even-parity bit, written on every store.
//   On load, any accessed byte with a parity mismatch sets err=1; rdata is still returned.
//  DM_PARITY_EN undefined: no parity storage; err reflects only alignment/range/size.
// STRUCTURE
//  Package dm_pkg:
//   - size_t enum (SZ_B/SZ_H/SZ_W/SZ_D)
//   - state_t enum (IDLE/WAIT/ACCESS/RESP)
//   - function be_gen(size, lane) -> byte enables
//   - function ext(data, size, sext)
//  Sub-module dm_lane_align: combinational store shift + be gen and load extract/extend; the top holds FSM, counter and array.
// TESTING
//  LAT=1, DW=32: sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 -> ack 3 cycles after accept, rdata=0xDEADBEEF, err=0.
//  sb addr=0x13 wdata=0x000000A5 onto 0x11223344; lb sext=1 -> 0xFFFFFFA5; lbu -> 0x000000A5; lw -> 0xA5223344.
//  sh addr=0x12 wdata=0x8001; lh sext=1 -> 0xFFFF8001; lhu -> 0x00008001; low half is unchanged.
//  lw addr=0x11 (misaligned) -> ack with err=1, rdata=0; sw addr=0x11 -> err=1 and memory word 0x10 unchanged.
//  Address word index=DEPTH -> err=1; size=11 with DW=32 -> err=1; req held through RESP -> no second ack.
//  Reset asserted mid-WAIT -> ack never pulses, outputs 0. DM_PARITY_EN: force a flipped stored bit -> lw err=1.

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_pkg                                                               |
// | Shared types and lane helpers for the dm_hs data memory.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package dm_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Byte enables for an access of the given size starting at byte lane 'lane'
  function automatic logic [7:0] be_gen(input size_t size, input logic [2:0] lane);
    logic [7:0] m;
    unique case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lane;
  endfunction

  // Extend right-justified load data from bit (8<<size)-1; a dword is passed through
  function automatic logic [MAX_DW-1:0] ext(input logic [MAX_DW-1:0] data,
                                            input size_t size, input logic sext);
    logic [MAX_DW-1:0] r;
    unique case (size)
      SZ_B:    r = {{56{sext & data[7]}},  data[7:0]};
      SZ_H:    r = {{48{sext & data[15]}}, data[15:0]};
      SZ_W:    r = {{32{sext & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_hs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_hs_if                                                             |
// | req/ack handshake bus between the CPU datapath and dm_hs.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface dm_hs_if #(
  parameter int DW = 32,
  parameter int AW = 14
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [1:0]    size;
  logic          sext;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, we, addr, size, sext, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, size, sext, wdata,
    output ack, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_lane_align                                                        |
// | Combinational lane steering: store shift + byte enables, load        |
// | extract + sign/zero extension.                                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module dm_lane_align
  import dm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [$clog2(DW/8)-1:0] lane,
  input  size_t                   size,
  input  logic                    sext,
  input  logic [DW-1:0]           wdata,
  input  logic [DW-1:0]           rword,
  output logic [DW-1:0]           wword,
  output logic [DW/8-1:0]         be,
  output logic [DW-1:0]           rdata
);
  localparam int NB = DW / 8;

  logic [DW-1:0] rshift;

  // Move store data up into its lane and bring load data down to bit 0
  always_comb begin
    wword  = wdata << {lane, 3'b000};
    be     = NB'(be_gen(size, 3'(lane)));
    rshift = rword >> {lane, 3'b000};
    rdata  = DW'(ext(MAX_DW'(rshift), size, sext));
  end

endmodule
`default_nettype wire

// File: rtl/dm_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_hs                                                                |
// | Data memory with req/ack handshake and LAT wait states. Byte/half/   |
// | word(/dword) access, lane steering, misalign/range error flag.       |
// | Optional per-byte even parity: define DM_PARITY_EN.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module dm_hs
  import dm_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 3072,
  parameter int AW    = 14,
  parameter int LAT   = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  dm_hs_if.slave bus
);
  localparam int NB  = DW / 8;
  localparam int LB  = $clog2(NB);
  localparam int WIW = AW - LB;
  localparam int MIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (LAT > 0) ? CW'(LAT - 1) : '0;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // Request fields captured at accept time
  logic          we_l;
  logic [AW-1:0] addr_l;
  size_t         size_l;
  logic          sext_l;
  logic [DW-1:0] wdata_l;

  logic [DW-1:0] mem [DEPTH];

  logic [WIW-1:0] word_idx;
  logic [MIW-1:0] mem_idx;
  logic           in_range, aligned, size_ok, legal, perr, acc_err;
  logic [DW-1:0]  rword, wword, ld_data;
  logic [NB-1:0]  be;

  logic           resp_ack, resp_err;
  logic [DW-1:0]  resp_data;

  assign word_idx = addr_l[AW-1:LB];
  assign mem_idx  = word_idx[MIW-1:0];
  assign in_range = (32'(word_idx) < 32'(DEPTH));
  assign size_ok  = (size_l != SZ_D) || (DW == 64);
  assign legal    = aligned & size_ok & in_range;
  assign rword    = in_range ? mem[mem_idx] : '0;

  // Natural alignment: address must be a multiple of the access size
  always_comb begin
    aligned = 1'b0;
    unique case (size_l)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~addr_l[0];
      SZ_W:    aligned = (addr_l[1:0] == 2'b00);
      SZ_D:    aligned = (addr_l[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
  end

  dm_lane_align #(.DW(DW)) u_align (
    .lane  (addr_l[LB-1:0]),
    .size  (size_l),
    .sext  (sext_l),
    .wdata (wdata_l),
    .rword (rword),
    .wword (wword),
    .be    (be),
    .rdata (ld_data)
  );

`ifdef DM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] par_calc, par_word;

  assign par_word = in_range ? par[mem_idx] : '0;

  // Recompute even parity of the stored bytes and compare on the accessed lanes
  always_comb begin
    par_calc = '0;
    for (int b = 0; b < NB; b++) par_calc[b] = ^rword[8*b +: 8];
    perr = |(be & (par_calc ^ par_word));
  end

  // Parity bits follow every landed store byte
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_l && legal) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) par[mem_idx][b] <= ^wword[8*b +: 8];
    end
  end
`else
  assign perr = 1'b0;
`endif

  assign acc_err = ~legal | (~we_l & perr);

  // State and wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: accept in IDLE, burn LAT wait cycles, access, respond
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          state_nx = (LAT > 0) ? WAIT : ACCESS;
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_nx = ACCESS;
        else                 cnt_nx   = cnt + CW'(1);
      end
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the request once; later bus changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_l    <= 1'b0;
      addr_l  <= '0;
      size_l  <= SZ_B;
      sext_l  <= 1'b0;
      wdata_l <= '0;
    end else if (state == IDLE && bus.req) begin
      we_l    <= bus.we;
      addr_l  <= bus.addr;
      size_l  <= size_t'(bus.size);
      sext_l  <= bus.sext;
      wdata_l <= bus.wdata;
    end
  end

  // Response registers: populated on the ACCESS edge, zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_ack  <= 1'b0;
      resp_err  <= 1'b0;
      resp_data <= '0;
    end else if (state == ACCESS) begin
      resp_ack  <= 1'b1;
      resp_err  <= acc_err;
      resp_data <= (legal && !we_l) ? ld_data : '0;
    end else begin
      resp_ack  <= 1'b0;
      resp_err  <= 1'b0;
      resp_data <= '0;
    end
  end

  // Byte-masked array write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_l && legal) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[mem_idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  assign bus.ack   = resp_ack;
  assign bus.err   = resp_err;
  assign bus.rdata = resp_data;

endmodule
`default_nettype wire

// File: tb/tb_dm_hs.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dm_hs                                                             |
// | Directed + randomized bench for dm_hs against a byte-level model.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_dm_hs;
  localparam int DW    = 32;
  localparam int DEPTH = 3072;
  localparam int AW    = 14;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_hs_if #(.DW(DW), .AW(AW)) bus();

  dm_hs #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Byte-addressed reference memory
  logic [7:0] mm [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input int unsigned a, input int sz);
    return (sz != 3) && ((a % (1 << sz)) == 0) && ((a / 4) < DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input int unsigned a, input int sz, input bit sx);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[int'(a) + i];
    if (sx && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_store(input int unsigned a, input int sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) mm[int'(a) + i] = wd[8*i +: 8];
  endtask

  // One handshake; lat = cycle number (1 = cycle after accept edge) in which ack is seen
  task automatic xfer(input bit w, input int unsigned a, input int sz, input bit sx,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = w; bus.addr = AW'(a); bus.size = 2'(sz);
    bus.sext = sx; bus.wdata = wd;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        bus.we = ~w; bus.addr = AW'($urandom); bus.size = 2'($urandom);
        bus.sext = ~sx; bus.wdata = DW'($urandom);
      end
      if (bus.ack) begin lat = i; break; end
    end
    rd = bus.rdata;
    er = bus.err;
    bus.req = 1'b0;
  endtask

  task automatic op(input string tag, input bit w, input int unsigned a, input int sz,
                    input bit sx, input logic [31:0] wd, output logic [31:0] rd);
    logic er;
    int lat;
    bit lg;
    logic [31:0] exp_rd;
    lg = model_legal(a, sz);
    exp_rd = (!w && lg) ? model_load(a, sz, sx) : 32'h0;
    xfer(w, a, sz, sx, wd, rd, er, lat);
    check({tag, ".lat"}, 64'(lat), 64'(LAT + 2));
    check({tag, ".err"}, 64'(er), 64'(!lg));
    if (!w) check({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
    if (w && lg) model_store(a, sz, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, lat2, acks, sel, sz;
    int unsigned a;
    bit w, sx;

    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.size = 2'b00;
    bus.sext = 1'b0; bus.wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.ack", 64'(bus.ack), 64'(0));
    check("reset.err", 64'(bus.err), 64'(0));
    check("reset.rdata", 64'(bus.rdata), 64'(0));
    rst_n = 1'b1;

    // Initialise the region used later, including the last legal word
    for (int k = 0; k < 16; k++) op("init", 1'b1, 32'(4 * k), 2, 1'b0, $urandom, rd);
    op("init_last", 1'b1, 32'h2FFC, 2, 1'b0, $urandom, rd);

    // sw / lw round trip
    op("sw10", 1'b1, 32'h10, 2, 1'b0, 32'hDEADBEEF, rd);
    op("lw10", 1'b0, 32'h10, 2, 1'b0, 32'h0, rd);
    check("lw10.const", 64'(rd), 64'h0000_0000_DEAD_BEEF);
    @(posedge clk); #1;
    check("after_resp.ack", 64'(bus.ack), 64'(0));
    check("after_resp.rdata", 64'(bus.rdata), 64'(0));

    // Byte store into a known word
    op("sw_base", 1'b1, 32'h10, 2, 1'b0, 32'h11223344, rd);
    op("sb13", 1'b1, 32'h13, 0, 1'b0, 32'h000000A5, rd);
    op("lb13", 1'b0, 32'h13, 0, 1'b1, 32'h0, rd);
    check("lb13.const", 64'(rd), 64'hFFFF_FFA5);
    op("lbu13", 1'b0, 32'h13, 0, 1'b0, 32'h0, rd);
    check("lbu13.const", 64'(rd), 64'h0000_00A5);
    op("lw_sb", 1'b0, 32'h10, 2, 1'b0, 32'h0, rd);
    check("lw_sb.const", 64'(rd), 64'hA522_3344);

    // Half store into the upper half
    op("sh12", 1'b1, 32'h12, 1, 1'b0, 32'h00008001, rd);
    op("lh12", 1'b0, 32'h12, 1, 1'b1, 32'h0, rd);
    check("lh12.const", 64'(rd), 64'hFFFF_8001);
    op("lhu12", 1'b0, 32'h12, 1, 1'b0, 32'h0, rd);
    check("lhu12.const", 64'(rd), 64'h0000_8001);
    op("lw_sh", 1'b0, 32'h10, 2, 1'b0, 32'h0, rd);
    check("lw_sh.const", 64'(rd), 64'h8001_3344);

    // Misaligned and out-of-range accesses
    op("lw11", 1'b0, 32'h11, 2, 1'b0, 32'h0, rd);
    op("sw11", 1'b1, 32'h11, 2, 1'b0, 32'hFFFFFFFF, rd);
    op("lw10_keep", 1'b0, 32'h10, 2, 1'b0, 32'h0, rd);
    check("lw10_keep.const", 64'(rd), 64'h8001_3344);
    op("lw_oor", 1'b0, 32'(DEPTH * 4), 2, 1'b0, 32'h0, rd);
    op("sw_oor", 1'b1, 32'(DEPTH * 4), 2, 1'b0, 32'h12345678, rd);
    op("lw_last", 1'b0, 32'h2FFC, 2, 1'b0, 32'h0, rd);
    op("ld_dword", 1'b0, 32'h10, 3, 1'b0, 32'h0, rd);
    op("sd_dword", 1'b1, 32'h18, 3, 1'b0, 32'hCAFEF00D, rd);

    // req held through RESP: next ack only after a full new access
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = AW'(32'h10); bus.size = 2'b10; bus.sext = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin lat = i; break; end
    end
    check("held.first_lat", 64'(lat), 64'(LAT + 2));
    lat2 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin lat2 = i; break; end
    end
    check("held.period", 64'(lat2), 64'(LAT + 3));
    check("held.rdata", 64'(bus.rdata), 64'(model_load(32'h10, 2, 1'b0)));
    bus.req = 1'b0;
    @(posedge clk); #1;

    // Reset mid-WAIT abandons the access
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = AW'(32'h10); bus.size = 2'b10;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check("rst_wait.ack", 64'(bus.ack), 64'(0));
    check("rst_wait.rdata", 64'(bus.rdata), 64'(0));
    check("rst_wait.err", 64'(bus.err), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack) acks++;
    end
    check("rst_wait.no_ack", 64'(acks), 64'(0));
    op("lw_after_rst", 1'b0, 32'h10, 2, 1'b0, 32'h0, rd);

    // Randomized traffic against the byte model
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = $urandom_range(0, 63);
      else if (sel < 9) a = 32'h2FFC + $urandom_range(0, 3);
      else              a = 32'h3000 + $urandom_range(0, 255);
      sz = $urandom_range(0, 3);
      w  = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      op($sformatf("rnd%0d", k), w, a, sz, sx, $urandom, rd);
    end

`ifdef DM_PARITY_EN
    dut.mem[4][0] = ~dut.mem[4][0];
    xfer(1'b0, 32'h10, 2, 1'b0, 32'h0, rd, er, lat);
    check("parity.err", 64'(er), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
